// File: rtl/dm_wait_ram.sv
// dm_wait_ram: parametrised data memory with req/ready handshake, wait states, post-reset clear and range error.
// Optional DM_WRITE_READBACK_EN: in-range writes also load dout with the written data.
module dm_wait_ram #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int DEPTH = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          err,
  output logic          busy
);
  localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef DM_WRITE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] clr_cnt_q;
  logic [3:0]    wait_cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] dout_q;
  logic          ready_q;
  logic          err_q;
  logic          busy_q;
  logic [DW-1:0] mem [DEPTH];
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_din;
  logic [CW-1:0] idx;
  logic          in_range;
  logic          go_done;
  // With zero wait states the access completes straight from IDLE on the live inputs
  assign acc_we   = state_q == IDLE ? we : we_q;
  assign acc_addr = state_q == IDLE ? addr : addr_q;
  assign acc_din  = state_q == IDLE ? din : din_q;
  assign idx      = acc_addr[CW-1:0];
  assign in_range = {1'b0, acc_addr} < (AW+1)'(DEPTH);
  assign go_done  = (state_q == IDLE && req && WAIT_CYCLES == 0) ||
                    (state_q == WAIT && wait_cnt_q == 4'd1);
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[clr_cnt_q] <= '0;
    else if (go_done && acc_we && in_range) mem[idx] <= acc_din;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      ready_q <= go_done;
      err_q   <= go_done && !in_range;
      if (go_done && in_range && (!acc_we || RB)) dout_q <= acc_we ? acc_din : mem[idx];
      case (state_q)
        CLEAR: begin
          if (clr_cnt_q == CW'(DEPTH-1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else clr_cnt_q <= clr_cnt_q + 1'b1;
        end
        IDLE: begin
          if (req) begin
            we_q       <= we;
            addr_q     <= addr;
            din_q      <= din;
            wait_cnt_q <= 4'(WAIT_CYCLES);
            state_q    <= WAIT_CYCLES == 0 ? DONE : WAIT;
          end
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q - 1'b1;
          if (wait_cnt_q == 4'd1) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
  assign dout  = dout_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_dm_wait_ram.sv
// tb_dm_wait_ram: randomized checks of three dm_wait_ram instances (WAIT_CYCLES 1, 0, 4) against a behavioural memory model.
module tb_dm_wait_ram;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_s [3];
  logic        we_s [3];
  logic [7:0]  addr_s [3];
  logic [15:0] din_s [3];
  logic [15:0] dout_o [3];
  logic        ready_o [3];
  logic        err_o [3];
  logic        busy_o [3];
  logic [15:0] ref_mem [3][16];
  logic [15:0] ref_dout [3];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dm_wait_ram #(.WAIT_CYCLES(1)) dut0 (.clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]),
    .addr(addr_s[0]), .din(din_s[0]), .dout(dout_o[0]), .ready(ready_o[0]), .err(err_o[0]), .busy(busy_o[0]));
  dm_wait_ram #(.WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]),
    .addr(addr_s[1]), .din(din_s[1]), .dout(dout_o[1]), .ready(ready_o[1]), .err(err_o[1]), .busy(busy_o[1]));
  dm_wait_ram #(.WAIT_CYCLES(4)) dut2 (.clk(clk), .reset(reset), .req(req_s[2]), .we(we_s[2]),
    .addr(addr_s[2]), .din(din_s[2]), .dout(dout_o[2]), .ready(ready_o[2]), .err(err_o[2]), .busy(busy_o[2]));

  function automatic int wc(input int k);
    return k == 0 ? 1 : (k == 1 ? 0 : 4);
  endfunction

  task automatic model_clear;
    for (int k = 0; k < 3; k++) begin
      ref_dout[k] = '0;
      for (int i = 0; i < 16; i++) ref_mem[k][i] = '0;
    end
  endtask

  // Starts from just after an edge with the instance idle; acceptance happens at the next edge
  task automatic run(input int k, input bit w, input logic [7:0] a, input logic [15:0] d, input bit scr);
    int n;
    bit oor;
    oor = a >= 8'd16;
    we_s[k] = w; addr_s[k] = a; din_s[k] = d; req_s[k] = 1'b1;
    @(posedge clk); #1;
    req_s[k] = 1'b0;
    if (scr) begin
      addr_s[k] = 8'($urandom);
      din_s[k] = 16'($urandom);
    end
    n = 1;
    while (!ready_o[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!oor) begin
      if (w) begin
        ref_mem[k][a[3:0]] = d;
`ifdef DM_WRITE_READBACK_EN
        ref_dout[k] = d;
`endif
      end else ref_dout[k] = ref_mem[k][a[3:0]];
    end
    total++;
    if (n !== wc(k) + 1) begin
      bad++;
      $display("FAIL latency inst%0d addr=%0h: got %0d cycles, want %0d", k, a, n, wc(k) + 1);
    end
    total++;
    if (err_o[k] !== oor) begin
      bad++;
      $display("FAIL err inst%0d addr=%0h: got %b, want %b", k, a, err_o[k], oor);
    end
    total++;
    if (dout_o[k] !== ref_dout[k]) begin
      bad++;
      $display("FAIL dout inst%0d we=%0b addr=%0h: got %h, want %h", k, w, a, dout_o[k], ref_dout[k]);
    end
    @(posedge clk); #1;
    total++;
    if (ready_o[k] !== 1'b0 || err_o[k] !== 1'b0) begin
      bad++;
      $display("FAIL pulse inst%0d: ready=%b err=%b one cycle later, want 0 0", k, ready_o[k], err_o[k]);
    end
  endtask

  task automatic wait_clear(input string tag);
    int n;
    bit stray;
    n = 0;
    stray = 0;
    while (busy_o[0] && n < 40) begin
      for (int k = 0; k < 3; k++) if (ready_o[k] || err_o[k]) stray = 1;
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (busy_o[k] !== 1'b0) begin
        bad++;
        $display("FAIL %s busy inst%0d after clear: got %b, want 0", tag, k, busy_o[k]);
      end
    end
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL %s busy length: got %0d cycles, want 16", tag, n);
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL %s ready/err during clear: got 1, want 0", tag);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_s[k] = 1'b1; we_s[k] = 1'b0; addr_s[k] = 8'd5; din_s[k] = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (dout_o[k] !== 16'h0 || ready_o[k] !== 1'b0 || err_o[k] !== 1'b0 || busy_o[k] !== 1'b1) begin
        bad++;
        $display("FAIL reset inst%0d: dout=%h ready=%b err=%b busy=%b, want 0000 0 0 1",
                 k, dout_o[k], ready_o[k], err_o[k], busy_o[k]);
      end
    end
    model_clear();
    reset = 1'b0;
    wait_clear("reset");
    fork
      run(0, 1'b0, 8'd5, 16'h0, 1'b0);
      run(1, 1'b0, 8'd5, 16'h0, 1'b0);
      run(2, 1'b0, 8'd5, 16'h0, 1'b0);
    join
  endtask

  task automatic test_write_read;
    run(0, 1'b1, 8'd3, 16'hfffe, 1'b0);
    run(0, 1'b0, 8'd3, 16'h0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      run($urandom_range(0, 2), 1'($urandom), 8'($urandom_range(0, 19)), 16'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back(input int k);
    int n;
    logic [7:0] a;
    a = 8'($urandom_range(0, 15));
    we_s[k] = 1'b0; addr_s[k] = a; req_s[k] = 1'b1;
    n = 0;
    while (!ready_o[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ready_o[k] && n < 40);
      total++;
      if (n !== wc(k) + 2) begin
        bad++;
        $display("FAIL b2b interval inst%0d: got %0d cycles, want %0d", k, n, wc(k) + 2);
      end
      total++;
      if (dout_o[k] !== ref_mem[k][a[3:0]]) begin
        bad++;
        $display("FAIL b2b dout inst%0d addr=%0h: got %h, want %h", k, a, dout_o[k], ref_mem[k][a[3:0]]);
      end
    end
    req_s[k] = 1'b0;
    ref_dout[k] = ref_mem[k][a[3:0]];
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range;
    run(0, 1'b1, 8'd0, 16'h5a5a, 1'b0);
    run(0, 1'b0, 8'd9, 16'h0, 1'b0);
    run(0, 1'b1, 8'h20, 16'h1234, 1'b0);
    run(0, 1'b0, 8'hff, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) run(0, 1'b0, 8'(i), 16'h0, 1'b0);
  endtask

  task automatic test_mid_reset;
    bit seen;
    we_s[0] = 1'b1; addr_s[0] = 8'd7; din_s[0] = 16'hffff; req_s[0] = 1'b1;
    @(posedge clk); #1;
    req_s[0] = 1'b0;
    reset = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready_o[0]) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort ready: got 1, want 0");
    end
    total++;
    if (busy_o[0] !== 1'b1 || dout_o[0] !== 16'h0) begin
      bad++;
      $display("FAIL abort state: busy=%b dout=%h, want 1 0000", busy_o[0], dout_o[0]);
    end
    model_clear();
    #1 reset = 1'b0;
    wait_clear("midreset");
    run(0, 1'b0, 8'd7, 16'h0, 1'b0);
  endtask

  task automatic test_holdoff;
    run(2, 1'b1, 8'd9, 16'h0f0f, 1'b0);
    run(2, 1'b0, 8'd9, 16'h0, 1'b0);
    run(2, 1'b1, 8'd9, 16'hffff, 1'b1);
    run(2, 1'b0, 8'd9, 16'h0, 1'b1);
    run(0, 1'b1, 8'd4, 16'hffff, 1'b1);
    run(0, 1'b0, 8'd4, 16'h0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; din_s[k] = '0;
    end
    reset = 1'b1;
    #2;
    test_reset();
    test_write_read();
    test_random();
    test_back_to_back(1);
    test_back_to_back(2);
    test_back_to_back(0);
    test_out_of_range();
    test_holdoff();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
